cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port cpu_req, input, 1, CPU access request, held until cpu_done.
REQ-004 SHALL have port cpu_we, input, 1, store (1) or load (0); stable while cpu_req.
REQ-005 SHALL have port cpu_addr, input, 32, byte address; fields [31:8] tag, [7:4] set, [3:2] word.
REQ-006 SHALL have port cpu_wdata, input, 32, store data.
REQ-007 SHALL have port cpu_stall, output, 1, CPU must hold the current request.
REQ-008 SHALL have port cpu_done, output, 1, one-cycle access-complete pulse.
REQ-009 SHALL have ports cache_hit (input, 1) and cache_hit_way (input, 1), combinational lookup result for cpu_addr.
REQ-010 SHALL have port cache_we, output, 1, one-cycle store-hit write strobe to the cache.
REQ-011 SHALL have fill ports, all outputs: fill_en (1), fill_set (4), fill_way (1), fill_word (2), fill_data (32), fill_tag (24), fill_valid (1).
REQ-012 SHALL have memory ports: mem_req, mem_we, mem_addr (32), mem_wdata (32) as outputs; mem_ack (1) and mem_rdata (32) as inputs.

Function
REQ-013 SHALL implement the states IDLE, FILL and WRITE with a 2-bit state register.
REQ-014 SHALL keep one LRU bit per set (16 bits); the value names the victim way.
REQ-015 Load hit in IDLE SHALL behave as follows: cpu_done=1 and cpu_stall=0 in the same cycle; lru[set] <= ~cache_hit_way; state stays IDLE.
REQ-016 Load miss in IDLE SHALL behave as follows: cpu_stall=1; latch tag/set; victim <= lru[set]; word counter <= 0; go to FILL.
REQ-017 In FILL, the block SHALL hold mem_req=1, mem_we=0 and mem_addr={tag,set,cnt,2'b00} until mem_ack.
REQ-018 On each mem_ack in FILL, the block SHALL drive fill_en=1 for that cycle, with fill_data=mem_rdata, fill_word=cnt, fill_way=victim, fill_set and fill_tag from the latched values; the counter then increments.
REQ-019 On the mem_ack for cnt=3, the block SHALL drive fill_valid=1 in the same cycle, set lru[set] <= ~victim, and return to IDLE.
REQ-020 After a fill, the block SHALL replay the held load in IDLE, where it now hits; a fill costs 4 acks plus 1 cycle.
REQ-021 On a store in IDLE, the block SHALL go to WRITE (write-through, no write-allocate); it latches addr, wdata, hit and hit_way; cpu_stall=1.
REQ-022 In WRITE, the block SHALL hold mem_req=1, mem_we=1, mem_addr=latched addr and mem_wdata=latched wdata until mem_ack.
REQ-023 On the WRITE mem_ack, the block SHALL assert cpu_done=1 and cache_we = latched hit; if hit, lru[set] <= ~hit_way; then go to IDLE.
REQ-024 Store miss SHALL leave the cache and LRU untouched.
REQ-025 cpu_stall SHALL equal cpu_req & ~cpu_done at all times.
REQ-026 mem_ack SHALL be ignored when mem_req=0.
REQ-027 mem_req SHALL stay high across back-to-back fill words; mem_addr SHALL change only on an ack.
REQ-028 cpu_req and cpu_addr changes SHALL be ignored outside IDLE; latched values govern the operation.
REQ-029 fill_en, fill_valid, cache_we and cpu_done SHALL each be asserted for no more than one cycle per event.
REQ-030 The counter SHALL wrap 3->0 only on FILL exit.
REQ-031 A latency of 1 cycle from mem_req to mem_ack SHALL be supported: an ack in the first FILL cycle is accepted.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL set state=IDLE, all LRU bits=0, counter=0 and all latches=0.
REQ-033 During and after reset, the block SHALL drive mem_req, mem_we, fill_en, fill_valid, cache_we and cpu_done at 0; cpu_stall SHALL follow REQ-025.
REQ-034 Reset mid-FILL SHALL abandon the fill with no fill_valid; a partially written line SHALL remain invalid.
REQ-035 Reset mid-WRITE SHALL drop the request with no cpu_done and no cache_we.

Verification
REQ-036 Load 0x0000_0040, cache_hit=1, way 1 -> cpu_done in the same cycle; lru[4] becomes 0.
REQ-037 Load 0x0000_1234 miss, lru[3]=0, ack every cycle -> mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C; fill_way=0; fill_valid on the 4th ack; replay hit; lru[3]=1.
REQ-038 Store 0x0000_0080 with data 0xDEADBEEF, hit way 0, ack after 3 cycles -> mem_we=1 throughout; cpu_done and cache_we pulse on the ack cycle; lru[8]=1.
REQ-039 Store miss to 0x0000_2000 -> memory write occurs; cache_we=0; no fill_en; LRU unchanged.
REQ-040 Assert rst after the 2nd fill ack -> next cycle state=IDLE, mem_req=0, no fill_valid; the reissued load misses again and refetches from word 0.
REQ-041 Two loads missing in the same set (different tags) -> first fill goes to way 0, second fill goes to way 1.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// CPU, cache-array and memory signals of the cache controller, bundled as one bus.
// The master side is the environment (CPU, tag lookup, memory); the slave side is cache_ctrl.
interface cache_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_done;

    logic        cache_hit;
    logic        cache_hit_way;
    logic        cache_we;

    logic        fill_en;
    logic [3:0]  fill_set;
    logic        fill_way;
    logic [1:0]  fill_word;
    logic [31:0] fill_data;
    logic [23:0] fill_tag;
    logic        fill_valid;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cache_hit, cache_hit_way,
        output mem_ack, mem_rdata,
        input  cpu_stall, cpu_done, cache_we,
        input  fill_en, fill_set, fill_way, fill_word, fill_data, fill_tag, fill_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cache_hit, cache_hit_way,
        input  mem_ack, mem_rdata,
        output cpu_stall, cpu_done, cache_we,
        output fill_en, fill_set, fill_way, fill_word, fill_data, fill_tag, fill_valid,
        output mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_ctrl.sv
// Controller for a 2-way, 16-set cache with 4-word lines: load hits finish in one cycle,
// load misses fill the LRU way, stores write through to memory without allocating.
module cache_ctrl (
    input logic         clk,
    input logic         rst,
    cache_ctrl_if.slave bus
);
    // state | meaning
    // IDLE  | accept a CPU request; load hits (including the post-fill replay) complete here
    // FILL  | fetch the four words of the missed line into the victim way
    // WRITE | write the latched store through to memory
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] lru;
    logic [1:0]  cnt;
    logic [23:0] tag_q;
    logic [3:0]  set_q;
    logic        victim_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        hit_q;
    logic        hit_way_q;

    logic [3:0]  req_set;
    logic        load_hit;
    logic        fill_ack;
    logic        write_ack;

    assign req_set = bus.cpu_addr[7:4];

    // Every strobe is gated by rst so an ack landing in a reset cycle completes nothing.
    assign load_hit  = !rst && (state == IDLE) && bus.cpu_req && !bus.cpu_we && bus.cache_hit;
    assign fill_ack  = !rst && (state == FILL) && bus.mem_ack;
    assign write_ack = !rst && (state == WRITE) && bus.mem_ack;

    assign bus.cpu_done  = load_hit || write_ack;
    assign bus.cpu_stall = bus.cpu_req && !bus.cpu_done;
    assign bus.cache_we  = write_ack && hit_q;

    assign bus.fill_en    = fill_ack;
    assign bus.fill_valid = fill_ack && (cnt == 2'd3);
    assign bus.fill_set   = set_q;
    assign bus.fill_way   = victim_q;
    assign bus.fill_word  = cnt;
    assign bus.fill_data  = bus.mem_rdata;
    assign bus.fill_tag   = tag_q;

    // The fill address is built from latched fields, so it only moves when cnt steps on an ack.
    assign bus.mem_req   = !rst && (state != IDLE);
    assign bus.mem_we    = !rst && (state == WRITE);
    assign bus.mem_addr  = (state == WRITE) ? addr_q : {tag_q, set_q, cnt, 2'b00};
    assign bus.mem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lru       <= '0;
            cnt       <= '0;
            tag_q     <= '0;
            set_q     <= '0;
            victim_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            hit_q     <= 1'b0;
            hit_way_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        if (bus.cpu_we) begin
                            addr_q    <= bus.cpu_addr;
                            wdata_q   <= bus.cpu_wdata;
                            hit_q     <= bus.cache_hit;
                            hit_way_q <= bus.cache_hit_way;
                            set_q     <= req_set;
                            state     <= WRITE;
                        end else if (bus.cache_hit) begin
                            lru[req_set] <= ~bus.cache_hit_way;
                        end else begin
                            tag_q    <= bus.cpu_addr[31:8];
                            set_q    <= req_set;
                            victim_q <= lru[req_set];
                            cnt      <= 2'd0;
                            state    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            lru[set_q] <= ~victim_q;
                            state      <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        if (hit_q) begin
                            lru[set_q] <= ~hit_way_q;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed scenarios then random loads/stores, checked against a
// line-level cache/LRU model with a behavioural tag array and memory around the DUT.
module tb_cache_ctrl;
    typedef struct packed {
        logic [1:0]  word;
        logic        way;
        logic [3:0]  set;
        logic [23:0] tag;
        logic [31:0] data;
        logic        valid;
    } fill_t;

    logic clk = 1'b0;
    logic rst;

    cache_ctrl_if bus ();
    cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Environment tag array (written from the DUT's fill port) and the reference model.
    bit        env_valid [16][2];
    bit [23:0] env_tag   [16][2];
    bit        ref_valid [16][2];
    bit [23:0] ref_tag   [16][2];
    bit        ref_lru   [16];

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_addr_q [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    fill_t       fills [$];

    int   lat = 0;
    int   wait_cnt = 0;
    logic force_ack = 1'b0;
    int   n_fvalid = 0, n_cwe = 0, n_done = 0, n_req_cyc = 0, n_we_cyc = 0, n_stall_bad = 0;
    logic last_fill_way = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [15:0] lru_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = ref_lru[i];
        return v;
    endfunction

    always_comb begin
        bus.cache_hit     = 1'b0;
        bus.cache_hit_way = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (env_valid[bus.cpu_addr[7:4]][w] && env_tag[bus.cpu_addr[7:4]][w] == bus.cpu_addr[31:8]) begin
                bus.cache_hit     = 1'b1;
                bus.cache_hit_way = w[0];
            end
        end
    end

    // Memory: acks after `lat` idle cycles per beat; lat=0 acks every cycle.
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) begin
            if (wait_cnt == 0) begin
                bus.mem_ack = 1'b1;
                wait_cnt    = lat;
                if (bus.mem_we) begin
                    mem[bus.mem_addr] = bus.mem_wdata;
                    wr_addr_q.push_back(bus.mem_addr);
                    wr_data_q.push_back(bus.mem_wdata);
                end else begin
                    bus.mem_rdata = mem_rd(bus.mem_addr);
                    rd_addr_q.push_back(bus.mem_addr);
                end
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt--;
            end
        end else begin
            bus.mem_ack = force_ack;
            wait_cnt    = lat;
        end
    end

    always @(negedge clk) begin
        #2;
        if (bus.cpu_stall !== (bus.cpu_req & ~bus.cpu_done)) n_stall_bad++;
        if (bus.mem_req === 1'b1) begin
            n_req_cyc++;
            if (bus.mem_we === 1'b1) n_we_cyc++;
        end
        if (bus.cache_we === 1'b1) n_cwe++;
        if (bus.cpu_done === 1'b1) n_done++;
        if (bus.fill_valid === 1'b1) n_fvalid++;
        if (bus.fill_en === 1'b1) begin
            fills.push_back('{bus.fill_word, bus.fill_way, bus.fill_set, bus.fill_tag, bus.fill_data, bus.fill_valid});
            env_valid[bus.fill_set][bus.fill_way] = 1'b0;
            if (bus.fill_valid === 1'b1) begin
                env_valid[bus.fill_set][bus.fill_way] = 1'b1;
                env_tag[bus.fill_set][bus.fill_way]   = bus.fill_tag;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int l);
        logic [3:0]  s;
        logic [23:0] t;
        logic [31:0] wa;
        bit hit, hw, victim, done_seen;
        int cyc, exp_cyc, rd0, wr0, f0, fv0, cwe0, dn0, rq0, we0;
        fill_t f;
        s = addr[7:4];
        t = addr[31:8];
        hit = 1'b0;
        hw  = 1'b0;
        for (int w = 0; w < 2; w++)
            if (ref_valid[s][w] && ref_tag[s][w] == t) begin
                hit = 1'b1;
                hw  = w[0];
            end
        victim = ref_lru[s];
        rd0 = rd_addr_q.size(); wr0 = wr_addr_q.size(); f0 = fills.size();
        fv0 = n_fvalid; cwe0 = n_cwe; dn0 = n_done; rq0 = n_req_cyc; we0 = n_we_cyc;
        lat = l;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        done_seen = 1'b0;
        cyc = 0;
        while (!done_seen && cyc <= 200) begin
            @(negedge clk); #3;
            if (bus.cpu_done === 1'b1) done_seen = 1'b1;
            else begin
                // Once the store is latched, the CPU-side inputs must no longer matter.
                if (we && cyc > 0) begin
                    bus.cpu_addr  = $urandom;
                    bus.cpu_wdata = $urandom;
                end
                cyc++;
            end
        end
        @(posedge clk); #1;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = addr;

        if (we) exp_cyc = l + 1;
        else if (hit) exp_cyc = 0;
        else exp_cyc = 4 * (l + 1) + 1;
        check("done_seen", done_seen, 1);
        check("latency", cyc, exp_cyc);
        check("done_pulses", n_done - dn0, 1);
        check("fill_valid_cnt", n_fvalid - fv0, (!we && !hit) ? 1 : 0);
        if (we) begin
            check("wr_cnt", wr_addr_q.size() - wr0, 1);
            if (wr_addr_q.size() > wr0) begin
                check("wr_addr", wr_addr_q[wr0], addr);
                check("wr_data", wr_data_q[wr0], wdata);
            end
            check("st_rd_cnt", rd_addr_q.size() - rd0, 0);
            check("st_fill_cnt", fills.size() - f0, 0);
            check("cache_we_cnt", n_cwe - cwe0, hit);
            check("st_we_cycles", n_we_cyc - we0, l + 1);
            check("st_req_cycles", n_req_cyc - rq0, l + 1);
            if (hit) ref_lru[s] = ~hw;
        end else if (hit) begin
            check("hit_rd_cnt", rd_addr_q.size() - rd0, 0);
            check("hit_fill_cnt", fills.size() - f0, 0);
            check("hit_req_cycles", n_req_cyc - rq0, 0);
            ref_lru[s] = ~hw;
        end else begin
            check("miss_rd_cnt", rd_addr_q.size() - rd0, 4);
            check("miss_fill_cnt", fills.size() - f0, 4);
            check("miss_we_cycles", n_we_cyc - we0, 0);
            check("miss_req_cycles", n_req_cyc - rq0, 4 * (l + 1));
            check("miss_cache_we", n_cwe - cwe0, 0);
            if (rd_addr_q.size() >= rd0 + 4 && fills.size() >= f0 + 4) begin
                last_fill_way = fills[f0].way;
                for (int i = 0; i < 4; i++) begin
                    wa = {addr[31:4], i[1:0], 2'b00};
                    f  = fills[f0 + i];
                    check("rd_addr", rd_addr_q[rd0 + i], wa);
                    check("fill_word", f.word, i[1:0]);
                    check("fill_way", f.way, victim);
                    check("fill_set", f.set, s);
                    check("fill_tag", f.tag, t);
                    check("fill_data", f.data, mem_rd(wa));
                    check("fill_valid_pos", f.valid, (i == 3) ? 1 : 0);
                end
            end
            ref_valid[s][victim] = 1'b1;
            ref_tag[s][victim]   = t;
            ref_lru[s]           = ~victim;
        end
        check("lru", dut.lru, lru_vec());
    endtask

    logic [31:0] ra;
    int f0, fv0, dn0, cwe0, wr0;

    initial begin
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

        // Reset: strobes low, LRU cleared, stall follows the held request.
        repeat (2) @(posedge clk);
        #1 bus.cpu_req = 1'b1;
        @(negedge clk); #3;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_fill_en", bus.fill_en, 0);
        check("rst_fill_valid", bus.fill_valid, 0);
        check("rst_cache_we", bus.cache_we, 0);
        check("rst_cpu_done", bus.cpu_done, 0);
        check("rst_cpu_stall", bus.cpu_stall, 1);
        check("rst_lru", dut.lru, 16'h0000);
        check("rst_state", dut.state, 0);
        @(posedge clk); #1 bus.cpu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // Way 1 of set 4 holds 0x40; the hit then points LRU back at way 0.
        do_op(1'b0, 32'h0000_1040, '0, 0);
        do_op(1'b0, 32'h0000_0040, '0, 0);
        do_op(1'b0, 32'h0000_0040, '0, 0);
        check("req036_lru4", dut.lru[4], 0);

        do_op(1'b0, 32'h0000_1234, '0, 0);
        check("req037_lru3", dut.lru[3], 1);
        check("req037_way", last_fill_way, 0);

        do_op(1'b0, 32'h0000_0080, '0, 1);
        do_op(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 3);
        check("req038_lru8", dut.lru[8], 1);

        do_op(1'b1, 32'h0000_2000, 32'h1234_5678, 1);

        // Acks with no request outstanding must be ignored.
        f0 = fills.size(); dn0 = n_done;
        @(posedge clk); #1 force_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 force_ack = 1'b0;
        @(negedge clk); #3;
        check("spur_fill", fills.size() - f0, 0);
        check("spur_done", n_done - dn0, 0);
        check("spur_state", dut.state, 0);
        check("spur_lru", dut.lru, lru_vec());

        do_op(1'b0, 32'h0000_3050, '0, 0);
        check("req041_first_way", last_fill_way, 0);
        do_op(1'b0, 32'h0000_4050, '0, 2);
        check("req041_second_way", last_fill_way, 1);

        // Reset after the second fill beat: line abandoned, reload refetches from word 0.
        f0 = fills.size(); fv0 = n_fvalid; dn0 = n_done;
        lat = 0;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_2060;
        for (int c = 0; c < 50 && fills.size() - f0 < 2; c++) begin
            @(negedge clk); #3;
        end
        check("mfill_two_beats", fills.size() - f0, 2);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); #3;
        check("mfill_rst_mem_req", bus.mem_req, 0);
        check("mfill_rst_done", bus.cpu_done, 0);
        @(posedge clk); #1;
        rst = 1'b0; bus.cpu_req = 1'b0;
        @(negedge clk); #3;
        check("mfill_state", dut.state, 0);
        check("mfill_mem_req", bus.mem_req, 0);
        check("mfill_no_valid", n_fvalid - fv0, 0);
        check("mfill_no_done", n_done - dn0, 0);
        check("mfill_line_invalid", env_valid[6][0], 0);
        for (int i = 0; i < 16; i++) ref_lru[i] = 1'b0;
        ref_valid[6][0] = 1'b0;
        check("mfill_lru", dut.lru, 16'h0000);
        do_op(1'b0, 32'h0000_2060, '0, 0);

        // Reset mid-write: store dropped, no completion.
        wr0 = wr_addr_q.size(); dn0 = n_done; cwe0 = n_cwe;
        lat = 6;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_0070; bus.cpu_wdata = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); #3;
        check("mwr_rst_mem_req", bus.mem_req, 0);
        check("mwr_rst_stall", bus.cpu_stall, 1);
        @(posedge clk); #1;
        rst = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        check("mwr_no_write", wr_addr_q.size() - wr0, 0);
        check("mwr_no_done", n_done - dn0, 0);
        check("mwr_no_cache_we", n_cwe - cwe0, 0);
        check("mwr_state", dut.state, 0);
        for (int i = 0; i < 16; i++) ref_lru[i] = 1'b0;

        // Random mix over a few sets and tags so lines get evicted.
        for (int k = 0; k < 60; k++) begin
            ra = {24'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
            do_op($urandom_range(0, 2) == 0, ra, $urandom, int'($urandom_range(0, 3)));
        end

        check("stall_rule", n_stall_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
